// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I memory stage: LB/LH/LW/LBU/LHU loads, SB/SH/SW stores, fault flagging.
// Latency: response registered WAIT_CYCLES edges after the accept edge (requester samples it one edge later).
// Backpressure: one request in flight; req_ready only in IDLE, response held stable until rsp_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake; req_write, req_addr, req_wdata, req_funct3 latched on accept
//   rsp_valid/rsp_ready response handshake; rsp_rdata (extended load data, 0 for stores/faults), rsp_err
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [7:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    // With zero wait states the access happens on the accept edge itself, so the
    // access logic reads the live request in IDLE and the latched copy otherwise.
    logic        w_write;
    logic [31:0] w_addr, w_wdata, w_off, w_word, w_load, w_wrep;
    logic [2:0]  w_funct3;
    logic [AW-1:0] w_idx;
    logic        w_oor, w_misalign, w_illegal, w_err, w_access;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_write  = (r_state == S_IDLE) ? req_write  : r_write;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_oor      = {1'b0, w_off} >= LIMIT;
    assign w_misalign = ((w_funct3[1:0] == 2'b01) && w_off[0]) ||
                        ((w_funct3[1:0] == 2'b10) && (w_off[1:0] != 2'b00));
    // Stores: only SB/SH/SW. Loads: everything except 011, 110, 111.
    assign w_illegal  = w_write ? (w_funct3[2] || (w_funct3[1:0] == 2'b11))
                                : ((w_funct3[1:0] == 2'b11) || (w_funct3 == 3'b110));
    assign w_err      = w_oor || w_misalign || w_illegal;

    // Index is only meaningful when in range; the read result is discarded otherwise.
    assign w_word = r_mem[w_idx];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[8*w_off[1:0] +: 8];
        w_load = 32'd0;
        w_be   = 4'b0000;
        w_wrep = w_wdata;
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        case (w_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_off[1:0];
                w_wrep = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_off[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{w_wdata[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 8'd0) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The access fires on the edge that enters RESP; rst gating keeps a request
    // presented during reset from committing a store.
    assign w_access = !rst && (r_state != S_RESP) && (w_next == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_write  <= req_write;
                    r_addr   <= req_addr;
                    r_wdata  <= req_wdata;
                    r_funct3 <= req_funct3;
                    r_cnt    <= CNT_INIT;
                end
                S_WAIT: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (w_write || w_err) ? 32'd0 : w_load;
            r_err   <= w_err;
        end
    end

    // Storage is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_access && w_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          WA = 2;
    localparam int          DA = 64;
    localparam int          WB = 0;
    localparam int          DB = 16;
    localparam logic [31:0] BB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        vld_a, rdy_a, rspv_a, rsprdy_a, err_a;
    logic [31:0] rdata_a;
    logic        vld_b, rdy_b, rspv_b, rsprdy_b, err_b;
    logic [31:0] rdata_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // Byte-addressed reference memories (little-endian by construction).
    logic [7:0] mem_a [DA*4];
    logic [7:0] mem_b [DB*4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH_WORDS(DA), .WAIT_CYCLES(WA), .BASE_ADDR(32'h0)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rspv_a), .rsp_ready(rsprdy_a), .rsp_rdata(rdata_a), .rsp_err(err_a));

    dmem_responder #(.DEPTH_WORDS(DB), .WAIT_CYCLES(WB), .BASE_ADDR(BB)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rspv_b), .rsp_ready(rsprdy_b), .rsp_rdata(rdata_b), .rsp_err(err_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_rdata(input int sel); return sel ? rdata_b : rdata_a; endfunction
    function automatic logic        o_err  (input int sel); return sel ? err_b   : err_a;   endfunction
    function automatic logic        o_valid(input int sel); return sel ? rspv_b  : rspv_a;  endfunction
    function automatic logic        o_ready(input int sel); return sel ? rdy_b   : rdy_a;   endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) vld_b = v; else vld_a = v;
    endtask

    // Reference: RV32I load/store semantics on a byte array; stores update it.
    function automatic void model(input int sel, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  output logic err, output logic [31:0] rd);
        logic [31:0] off, v;
        int sz, nbytes;
        logic legal;
        off    = addr - (sel ? BB : 32'h0);
        nbytes = sel ? DB*4 : DA*4;
        sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal  = wr ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err    = !legal || (off >= 32'(nbytes)) || ((off % 32'(sz)) != 0);
        rd     = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) begin
                    if (sel != 0) mem_b[int'(off) + i] = wdata[8*i +: 8];
                    else          mem_a[int'(off) + i] = wdata[8*i +: 8];
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) begin
                    if (sel != 0) v[8*i +: 8] = mem_b[int'(off) + i];
                    else          v[8*i +: 8] = mem_a[int'(off) + i];
                end
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
                rd = v;
            end
        end
    endfunction

    // Full transaction with rsp_ready held high; all expectations from the model.
    task automatic txn(input int sel, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          n;
        model(sel, wr, addr, wdata, f3, exp_er, exp_rd);
        check("req_ready_idle", 32'(o_ready(sel)), 32'd1);
        req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        set_valid(sel, 1'b1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        set_valid(sel, 1'b0);
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_write = 1'($urandom);
        n = 0;
        while (o_valid(sel) !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", 32'(n), 32'(sel ? WB : WA));
        check("rsp_err", 32'(o_err(sel)), 32'(exp_er));
        check("rsp_rdata", o_rdata(sel), exp_rd);
        rd = o_rdata(sel);
        er = o_err(sel);
        @(posedge clk); #1;
        check("rsp_valid_after_hs", 32'(o_valid(sel)), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, e_rd, e_rd2;
        logic        er, e_er, e_er2;
        int          n, a1;
        logic [31:0] addr;

        rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; rsprdy_a = 1'b1; rsprdy_b = 1'b1;
        req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        #1;
        check("rst_req_ready", 32'(rdy_a), 32'd1);
        check("rst_rsp_valid", 32'(rspv_a), 32'd0);
        check("rst_rsp_rdata", rdata_a, 32'd0);
        check("rst_rsp_err", 32'(err_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Give every word a known value so later loads have defined expectations.
        for (int w = 0; w < DA; w++) txn(0, 1'b1, 32'(4*w), $urandom, 3'b010, rd, er);
        for (int w = 0; w < DB; w++) txn(1, 1'b1, BB + 32'(4*w), $urandom, 3'b010, rd, er);

        // Word store then readback, sub-word loads, byte store.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
        check("sw_rdata_zero", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h13, 32'h0, 3'b000, rd, er);
        check("lb_13", rd, 32'hFFFFFFDE);
        txn(0, 1'b0, 32'h13, 32'h0, 3'b100, rd, er);
        check("lbu_13", rd, 32'h000000DE);
        txn(0, 1'b0, 32'h12, 32'h0, 3'b001, rd, er);
        check("lh_12", rd, 32'hFFFFDEAD);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b101, rd, er);
        check("lhu_10", rd, 32'h0000BEEF);
        txn(0, 1'b1, 32'h11, 32'h0000_0055, 3'b000, rd, er);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        check("lw_after_sb", rd, 32'hDEAD55EF);

        // Faults.
        txn(0, 1'b0, 32'h12, 32'h0, 3'b010, rd, er);
        check("lw_misaligned_err", 32'(er), 32'd1);
        check("lw_misaligned_data", rd, 32'd0);
        txn(0, 1'b1, 32'h11, 32'hFFFF_FFFF, 3'b001, rd, er);
        check("sh_misaligned_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        check("mem_unchanged", rd, 32'hDEAD55EF);
        txn(0, 1'b0, 32'(DA*4), 32'h0, 3'b010, rd, er);
        check("lw_oor_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b011, rd, er);
        check("ld_f3_011_err", 32'(er), 32'd1);

        // Backpressure: response held, a request waiting during RESP is taken only after IDLE.
        model(0, 1'b0, 32'h10, 32'h0, 3'b010, e_er, e_rd);
        model(0, 1'b0, 32'h14, 32'h0, 3'b010, e_er2, e_rd2);
        rsprdy_a = 1'b0;
        req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; vld_a = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h14;
        n = 0;
        while (rspv_a !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_latency", 32'(n), 32'(WA));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(rspv_a), 32'd1);
            check("bp_rdata_held", rdata_a, e_rd);
            check("bp_err_held", 32'(err_a), 32'(e_er));
            check("bp_req_ready_low", 32'(rdy_a), 32'd0);
        end
        rsprdy_a = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(rspv_a), 32'd0);
        check("bp_back_idle", 32'(rdy_a), 32'd1);
        @(posedge clk); #1;
        check("bp_pending_accepted", 32'(rdy_a), 32'd0);
        vld_a = 1'b0;
        n = 0;
        while (rspv_a !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_pending_latency", 32'(n), 32'(WA));
        check("bp_pending_rdata", rdata_a, e_rd2);
        @(posedge clk); #1;

        // Zero-wait build: response right after accept edge, initiation interval of 2.
        txn(1, 1'b0, BB + 32'h4, 32'h0, 3'b010, rd, er);
        a1 = acc_cyc;
        txn(1, 1'b0, BB + 32'h8, 32'h0, 3'b010, rd, er);
        check("b2b_interval", 32'(acc_cyc - a1), 32'd2);
        txn(1, 1'b0, BB - 32'h4, 32'h0, 3'b010, rd, er);
        check("below_base_err", 32'(er), 32'd1);

        // Reset during WAIT: store dropped, outputs cleared asynchronously.
        txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, er);
        txn(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010; vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_req_ready", 32'(rdy_a), 32'd1);
        check("arst_rsp_valid", 32'(rspv_a), 32'd0);
        check("arst_rsp_rdata", rdata_a, 32'd0);
        check("arst_rsp_err", 32'(err_a), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        txn(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        check("wait_reset_no_write", rd, 32'hCAFEF00D);

        // Reset during RESP: store already committed.
        rsprdy_a = 1'b0;
        model(0, 1'b1, 32'h24, 32'hA5A51234, 3'b010, e_er, e_rd);
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'hA5A51234; req_funct3 = 3'b010; vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        n = 0;
        while (rspv_a !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("resp_reset_latency", 32'(n), 32'(WA));
        rst = 1'b1;
        #1;
        check("resp_reset_valid", 32'(rspv_a), 32'd0);
        @(posedge clk); #1 rst = 1'b0; rsprdy_a = 1'b1;
        txn(0, 1'b0, 32'h24, 32'h0, 3'b010, rd, er);
        check("resp_reset_committed", rd, 32'hA5A51234);

        // Randomized traffic against the model, including faults and out-of-range words.
        for (int i = 0; i < 150; i++) begin
            addr = 32'(4 * $urandom_range(0, DA + 1)) + 32'($urandom_range(0, 3));
            txn(0, 1'($urandom), addr, $urandom, 3'($urandom_range(0, 7)), rd, er);
        end
        for (int i = 0; i < 60; i++) begin
            addr = BB + 32'(4 * $urandom_range(0, DB + 1)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = BB - 32'($urandom_range(1, 16));
            txn(1, 1'($urandom), addr, $urandom, 3'($urandom_range(0, 7)), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
